// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one uart_tx among N
// byte producers. A winner's byte is latched and acknowledged, the
// transmitter is strobed, and the grant is held until tx_ready shows the
// character has left the line. A granted port that holds lock (and still
// requests) keeps the transmitter for the next byte of its burst.
module uart_tx_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     lock,
    input  logic [8*N-1:0]   din,
    output logic [N-1:0]     ack,
    output logic [N-1:0]     grant,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    input  logic             tx_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);
    localparam logic [N-1:0]     ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_win;

    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_winner;
    logic               w_found;
    logic [PTR_W-1:0]   w_nextPtr;
    logic [N-1:0]       w_winOneHot;

    // Scan requests starting at the round-robin pointer and wrapping at N-1,
    // so non-power-of-two N never relies on natural counter overflow.
    always_comb begin
        w_idx    = r_ptr;
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
            if (w_idx == LAST_IDX) begin
                w_idx = '0;
            end else begin
                w_idx = w_idx + 1'b1;
            end
        end
    end

    // One-hot of the scan winner and the pointer value that follows the
    // current owner once its transfer has finished.
    always_comb begin
        w_winOneHot = ONE_HOT0 << w_winner;
        if (r_win == LAST_IDX) begin
            w_nextPtr = '0;
        end else begin
            w_nextPtr = r_win + 1'b1;
        end
    end

    // Sequencer: arbitration, byte latch, start strobe and ready tracking,
    // with every output registered here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_win    <= '0;
            grant    <= '0;
            ack      <= '0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            busy     <= 1'b0;
        end else begin
            ack      <= '0;
            tx_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tx_ready && w_found) begin
                        r_win   <= w_winner;
                        grant   <= w_winOneHot;
                        ack     <= w_winOneHot;
                        tx_data <= din[8*w_winner +: 8];
                        busy    <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    tx_start <= 1'b1;
                    r_state  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!tx_ready) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_ready) begin
                        if (lock[r_win] && req[r_win]) begin
                            ack     <= grant;
                            tx_data <= din[8*r_win +: 8];
                            r_state <= START;
                        end else begin
                            grant   <= '0;
                            busy    <= 1'b0;
                            r_ptr   <= w_nextPtr;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    grant   <= '0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a small uart_tx model answers
// tx_start, and a scoreboard of expected bytes is checked at every strobe.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int PTR_W = 2;

    logic           clk;
    logic           rstn;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [8*N-1:0] din;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_ready;
    logic           busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] sbQueue[$];

    int uartCycles = 10;
    int shiftCnt   = 0;
    bit forceLow   = 1'b0;

    uart_tx_arbiter #(.N(N), .PTR_W(PTR_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .lock     (lock),
        .din      (din),
        .ack      (ack),
        .grant    (grant),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_ready (tx_ready),
        .busy     (busy)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // uart_tx model: after sampling a start strobe the line is busy for
    // uartCycles clocks. It is deliberately not reset by rstn.
    always @(posedge clk) begin
        if (shiftCnt != 0) begin
            shiftCnt <= shiftCnt - 1;
        end else if (tx_start) begin
            shiftCnt <= uartCycles;
        end
    end
    assign tx_ready = (shiftCnt == 0) && !forceLow;

    // Scoreboard monitor: each start strobe must carry the oldest expected
    // byte, grant must never be multi-hot, and ack must be a single pulse
    // on the granted port.
    logic [N-1:0] prevAck = '0;
    always @(negedge clk) begin
        if (rstn) begin
            if (tx_start) begin
                checks++;
                if (sbQueue.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL scoreboard: unexpected tx_start with tx_data=%h, queue empty", tx_data);
                end else begin
                    logic [7:0] expByte;
                    expByte = sbQueue.pop_front();
                    if (tx_data !== expByte) begin
                        errors++;
                        $display("[TB] FAIL scoreboard: tx_data=%h expected %h", tx_data, expByte);
                    end
                end
            end
            if (grant != '0) begin
                checks++;
                if ($countones(grant) != 1) begin
                    errors++;
                    $display("[TB] FAIL grant_onehot: grant=%b expected one-hot", grant);
                end
            end
            if (ack != '0) begin
                checks++;
                if (ack !== grant || prevAck != '0) begin
                    errors++;
                    $display("[TB] FAIL ack_pulse: ack=%b prevAck=%b grant=%b expected ack==grant, single cycle", ack, prevAck, grant);
                end
            end
            prevAck = ack;
        end else begin
            prevAck = '0;
        end
    end

    // Global bound so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic doReset();
        @(negedge clk);
        req  = '0;
        lock = '0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic waitIdle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy && tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({grant, ack, tx_start, tx_data, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values: grant=%b ack=%b tx_start=%b tx_data=%h busy=%b expected all zero",
                     grant, ack, tx_start, tx_data, busy);
        end
        rstn = 1'b1;
    endtask

    task automatic test_single();
        int lowCnt;
        @(negedge clk);
        din[8*2 +: 8] = 8'h41;
        req = 4'b0100;
        sbQueue.push_back(8'h41);
        @(negedge clk);
        checks++;
        if (ack !== 4'b0100 || grant !== 4'b0100 || busy !== 1'b1 || tx_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ack: ack=%b grant=%b busy=%b tx_start=%b expected 0100 0100 1 0", ack, grant, busy, tx_start);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h41 || ack !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL single_start: tx_start=%b tx_data=%h ack=%b expected 1 41 0000", tx_start, tx_data, ack);
        end
        lowCnt = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!tx_ready) lowCnt++;
            else if (lowCnt > 0) break;
        end
        checks++;
        if (lowCnt != 10 || tx_ready !== 1'b1 || grant !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL single_hold: lowCnt=%0d tx_ready=%b grant=%b expected 10 1 0100", lowCnt, tx_ready, grant);
        end
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_release: grant=%b busy=%b expected 0000 0", grant, busy);
        end
    endtask

    task automatic test_round_robin();
        int acks;
        bit ok;
        logic [N-1:0] expAck;
        doReset();
        for (int i = 0; i < N; i++) din[8*i +: 8] = 8'h30 + 8'(i);
        sbQueue.push_back(8'h30);
        sbQueue.push_back(8'h31);
        sbQueue.push_back(8'h32);
        sbQueue.push_back(8'h33);
        sbQueue.push_back(8'h30);
        req = 4'b1111;
        acks = 0;
        for (int c = 0; c < 400 && acks < 5; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                expAck = 4'b0001 << (acks % N);
                checks++;
                if (ack !== expAck) begin
                    errors++;
                    $display("[TB] FAIL rr_order: ack=%b expected %b (transfer %0d)", ack, expAck, acks);
                end
                acks++;
                if (acks == 5) req = '0;
            end
        end
        waitIdle(100, ok);
        checks++;
        if (acks != 5 || !ok || sbQueue.size() != 0) begin
            errors++;
            $display("[TB] FAIL rr_complete: acks=%0d idle=%b queued=%0d expected 5 1 0", acks, ok, sbQueue.size());
        end
    endtask

    task automatic test_lock_burst();
        int nLock, riseCyc;
        bit prevRdy, gotPort3, grantBroke, ok;
        doReset();
        din[8*1 +: 8] = 8'h61;
        din[8*3 +: 8] = 8'h70;
        sbQueue.push_back(8'h61);
        sbQueue.push_back(8'h62);
        sbQueue.push_back(8'h63);
        sbQueue.push_back(8'h70);
        lock = 4'b0010;
        req  = 4'b1010;
        nLock = 0;
        riseCyc = 0;
        prevRdy = 1'b1;
        gotPort3 = 1'b0;
        grantBroke = 1'b0;
        for (int c = 0; c < 300 && !gotPort3; c++) begin
            @(negedge clk);
            if (!prevRdy && tx_ready) riseCyc = c;
            prevRdy = tx_ready;
            if (nLock >= 1 && nLock < 3 && grant !== 4'b0010) grantBroke = 1'b1;
            if (ack != '0) begin
                if (nLock < 3) begin
                    checks++;
                    if (ack !== 4'b0010 || grant !== 4'b0010) begin
                        errors++;
                        $display("[TB] FAIL lock_ack: ack=%b grant=%b expected 0010 0010", ack, grant);
                    end
                    if (nLock >= 1) begin
                        checks++;
                        if (c - riseCyc != 1) begin
                            errors++;
                            $display("[TB] FAIL lock_latency: ack %0d cycles after ready rise, expected 1", c - riseCyc);
                        end
                    end
                    nLock++;
                    if (nLock == 1) din[8*1 +: 8] = 8'h62;
                    if (nLock == 2) din[8*1 +: 8] = 8'h63;
                    if (nLock == 3) begin
                        lock = '0;
                        req[1] = 1'b0;
                    end
                end else begin
                    checks++;
                    if (ack !== 4'b1000 || grant !== 4'b1000) begin
                        errors++;
                        $display("[TB] FAIL lock_next: ack=%b grant=%b expected 1000 1000", ack, grant);
                    end
                    gotPort3 = 1'b1;
                    req = '0;
                end
            end
        end
        waitIdle(100, ok);
        checks++;
        if (!gotPort3 || grantBroke || !ok || sbQueue.size() != 0) begin
            errors++;
            $display("[TB] FAIL lock_complete: port3=%b grantBroke=%b idle=%b queued=%0d expected 1 0 1 0",
                     gotPort3, grantBroke, ok, sbQueue.size());
        end
    endtask

    task automatic test_ready_blocked();
        bit sawActivity, ok;
        doReset();
        forceLow = 1'b1;
        din[8*0 +: 8] = 8'h55;
        req = 4'b0001;
        sbQueue.push_back(8'h55);
        sawActivity = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack != '0 || tx_start || busy || grant != '0) sawActivity = 1'b1;
        end
        checks++;
        if (sawActivity) begin
            errors++;
            $display("[TB] FAIL blocked_idle: activity seen while tx_ready low, expected none");
        end
        forceLow = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL blocked_ack: ack=%b expected 0001", ack);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL blocked_start: tx_start=%b expected 1", tx_start);
        end
        waitIdle(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL blocked_idle_return: idle=%b expected 1", ok);
        end
    endtask

    task automatic test_reset_midtransfer();
        bit inDone, earlyAck, gotAck, ok;
        doReset();
        uartCycles = 30;
        din[8*3 +: 8] = 8'h5A;
        req = 4'b1000;
        sbQueue.push_back(8'h5A);
        inDone = 1'b0;
        for (int c = 0; c < 60 && !inDone; c++) begin
            @(negedge clk);
            if (ack != '0) req = '0;
            if (grant == 4'b1000 && !tx_ready) inDone = 1'b1;
        end
        @(negedge clk);
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (!inDone || grant !== '0 || tx_start !== 1'b0 || busy !== 1'b0 || ack !== '0 || tx_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL async_reset: reached=%b grant=%b tx_start=%b busy=%b ack=%b tx_data=%h expected 1 0000 0 0 0000 00",
                     inDone, grant, tx_start, busy, ack, tx_data);
        end
        @(negedge clk);
        rstn = 1'b1;
        uartCycles = 10;
        din[8*0 +: 8] = 8'h11;
        din[8*3 +: 8] = 8'h33;
        req = 4'b1001;
        sbQueue.push_back(8'h11);
        earlyAck = 1'b0;
        gotAck = 1'b0;
        for (int c = 0; c < 80 && !gotAck; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                gotAck = 1'b1;
                checks++;
                if (ack !== 4'b0001) begin
                    errors++;
                    $display("[TB] FAIL post_reset_winner: ack=%b expected 0001", ack);
                end
                req = '0;
            end else if (!tx_ready && busy) begin
                earlyAck = 1'b1;
            end
        end
        waitIdle(100, ok);
        checks++;
        if (!gotAck || earlyAck || !ok || sbQueue.size() != 0) begin
            errors++;
            $display("[TB] FAIL post_reset_complete: acked=%b busyWhileUartBusy=%b idle=%b queued=%0d expected 1 0 1 0",
                     gotAck, earlyAck, ok, sbQueue.size());
        end
    endtask

    task automatic test_withdraw();
        int extraAcks, starts;
        bit ok;
        doReset();
        din[8*0 +: 8] = 8'h77;
        din[8*1 +: 8] = 8'h88;
        req = 4'b0001;
        sbQueue.push_back(8'h77);
        @(negedge clk);
        checks++;
        if (ack !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL withdraw_ack: ack=%b expected 0001", ack);
        end
        req = '0;
        extraAcks = 0;
        starts = 0;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ack != '0) extraAcks++;
            if (tx_start) starts++;
            if (!busy && tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (extraAcks != 0 || starts != 1 || !ok) begin
            errors++;
            $display("[TB] FAIL withdraw_send: extraAcks=%0d starts=%0d idle=%b expected 0 1 1", extraAcks, starts, ok);
        end
        req = 4'b0011;
        sbQueue.push_back(8'h88);
        @(negedge clk);
        checks++;
        if (ack !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL withdraw_pointer: ack=%b expected 0010", ack);
        end
        req = '0;
        waitIdle(100, ok);
        checks++;
        if (!ok || sbQueue.size() != 0) begin
            errors++;
            $display("[TB] FAIL withdraw_complete: idle=%b queued=%0d expected 1 0", ok, sbQueue.size());
        end
    endtask

    // Test sequence.
    initial begin
        rstn = 1'b0;
        req  = '0;
        lock = '0;
        din  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock_burst();
        test_ready_blocked();
        test_reset_midtransfer();
        test_withdraw();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
